// File: rtl/pc_unit_ras.sv
// Fetch program counter with a prioritised next-PC select and a circular return-address stack.
// Priority per cycle: exception, return, call, branch, sequential.
module pc_unit_ras #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned STEP      = 1,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic                               exc,
  input  logic [ADDR_W-1:0]                  exc_vec,
  input  logic                               br_taken,
  input  logic [ADDR_W-1:0]                  br_target,
  input  logic                               call,
  input  logic                               ret,
  output logic [ADDR_W-1:0]                  pc,
  output logic [ADDR_W-1:0]                  pc_4,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
  output logic                               ras_overflow,
  output logic                               ras_underflow
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              push;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_top;

  assign pc_4    = pc_q + ADDR_W'(STEP);
  // ptr_q is the next write slot, so the newest entry sits one below it.
  assign ras_top = ras_mem[ptr_q - PtrW'(1)];

  always_comb begin
    pc_d  = pc_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    udf_d = 1'b0;
    push  = 1'b0;
    if (en) begin
      if (exc) begin
        pc_d = exc_vec;
      end else if (ret) begin
        if (cnt_q != '0) begin
          pc_d  = ras_top;
          ptr_d = ptr_q - PtrW'(1);
          cnt_d = cnt_q - CntW'(1);
        end else begin
          pc_d  = pc_4;
          udf_d = 1'b1;
        end
      end else if (call) begin
        pc_d  = br_target;
        push  = 1'b1;
        ptr_d = ptr_q + PtrW'(1);
        // A full stack keeps its count; the write slot is then the oldest entry.
        if (cnt_q == CntW'(RAS_DEPTH)) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end else if (br_taken) begin
        pc_d = br_target;
      end else begin
        pc_d = pc_4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= ADDR_W'(RESET_PC);
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      ras_mem[ptr_q] <= pc_4;
    end
  end

  assign pc            = pc_q;
  assign ras_count     = cnt_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = udf_q;

endmodule
